apb4_master: RTL and testbench
==============================

Name: apb4_master

Overview:
APB4 initiator (requester). It accepts single read/write commands on a valid/ready command port and drives the APB4 SETUP and ACCESS phases toward any APB4 completer, such as the team's register-bank slave bridge. It returns read data and error status on a valid/ready response port. A programmable timeout aborts transfers whose completer never asserts pready.

Parameters:
ADDR_WIDTH, 32, width of paddr and i_cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&&ready
i_cmd_write  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_WIDTH  target address
i_cmd_wdata  in  DATA_WIDTH  write data
i_cmd_strb  in  DATA_WIDTH/8  write byte strobes
i_cmd_prot  in  3  pprot value
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accepted when valid&&ready
o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
o_rsp_err  out  1  pslverr received or timeout
o_rsp_timeout  out  1  transfer aborted by timeout
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_pwrite  out  1  APB direction
m_paddr  out  ADDR_WIDTH  APB address
m_pwdata  out  DATA_WIDTH  APB write data
m_pstrb  out  DATA_WIDTH/8  APB strobes
m_pprot  out  3  APB protection
m_pready  in  1  completer ready
m_prdata  in  DATA_WIDTH  completer read data
m_pslverr  in  1  completer error

Behaviour:
- All outputs are registered. Reset value of every output is 0. rst asserted mid-transfer drops psel/penable immediately, discards any pending response and returns the FSM to IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: o_cmd_ready=1. On valid&&ready, latch the command into the APB output registers and go to SETUP. The command is captured in cycle N; psel=1, penable=0 in N+1.
- SETUP: lasts exactly one cycle, then ACCESS (penable=1). Clear the timeout counter.
- ACCESS: psel=penable=1. The address, control and data outputs hold stable.
  - If m_pready=1: capture prdata (reads only; writes give rdata=0) and pslverr. Drop psel/penable next cycle and go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 with pready still 0, abort: drop psel/penable, set err=1, timeout=1, rdata=0, go to RESP.
  - pready sampled on the abort cycle wins over the timeout.
- Minimum latency, zero wait states: command accepted in N, SETUP N+1, ACCESS N+2, o_rsp_valid=1 in N+3.
- RESP: o_rsp_valid=1 with fields stable until i_rsp_ready.
  - On accept, go to IDLE; o_cmd_ready rises the next cycle.
  - No command is accepted in SETUP, ACCESS or RESP: only one outstanding transfer.
- Reads force m_pstrb=0; writes pass i_cmd_strb unchanged, including all-zero strobes.
- m_pwdata is driven to 0 on reads.
- When the FSM is not in SETUP or ACCESS, psel=penable=0. The other APB outputs hold their last values.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- pslverr is ignored unless pready=1.

Decomposition:
- Package apb4_pkg:
  - apb4_state_e enum {IDLE, SETUP, ACCESS, RESP}
  - APB4_PROT_W=3 constant
  - typedef apb4_cmd_t struct {write, addr, wdata, strb, prot}, parameterized via localparams in the module
- One natural sub-module, apb4_timeout_counter: enable/clear/expired, parameter LIMIT, constant-0 expired when LIMIT=0.

Test Plan:
- Zero-wait write: cmd write addr 0x10, wdata 0xDEADBEEF, strb 0xF. Expect psel in N+1, penable in N+2, rsp_valid in N+3, err=0, pstrb=0xF on the bus.
- Read with 3 wait states: completer returns prdata 0x12345678 on the 4th ACCESS cycle. Expect rsp rdata=0x12345678, err=0, and paddr/pwrite stable throughout ACCESS.
- Slave error: write with pready=1, pslverr=1. Expect rsp err=1, timeout=0. Also pslverr=1 with pready=0 for 2 cycles has no effect until pready.
- Timeout: TIMEOUT_CYCLES=4, pready held 0. Expect psel dropped after 4 ACCESS cycles, rsp err=1, timeout=1, rdata=0. Repeat with pready asserted on the 4th cycle: expect a normal completion.
- Response backpressure: i_rsp_ready=0 for 5 cycles. Expect rsp fields stable, cmd_ready=0, and a second cmd_valid not accepted until the cycle after rsp accept.
- Reset mid-ACCESS: assert rst during wait states. Expect all outputs 0 asynchronously and FSM in IDLE. A new read after reset completes normally.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// -----------------------------------------------------------------------------
// apb4_pkg
// Shared types and constants for the APB4 initiator.
//   apb4_state_e : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   APB4_PROT_W  : width of pprot
// -----------------------------------------------------------------------------
package apb4_pkg;

    localparam int APB4_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_state_e;

endpackage

// File: rtl/apb4_master_if.sv
// -----------------------------------------------------------------------------
// apb4_master_if
// APB4 bus bundle between one initiator and one completer.
//   master modport : drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot,
//                    receives pready/prdata/pslverr
//   slave modport  : the mirror image
// -----------------------------------------------------------------------------
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import apb4_pkg::*;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [APB4_PROT_W-1:0]    pprot;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb4_master_timeout_counter.sv
// -----------------------------------------------------------------------------
// apb4_timeout_counter
// Counts ACCESS-phase wait cycles and flags the last permitted one.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : restart the count at 0 (takes priority over i_en)
//   i_en       : advance the count by one (saturating)
//   o_expired  : count has reached LIMIT-1; constant 0 when LIMIT == 0
// -----------------------------------------------------------------------------
module apb4_timeout_counter #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    // $clog2(1) is 0, so LIMIT == 0 still gets a one-bit counter.
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? (LIMIT - 1) : 0);
    localparam logic [CW-1:0] SAT  = {CW{1'b1}};

    logic [CW-1:0] r_count;

    // Wait-cycle count; stops at all-ones so a disabled timeout never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_en && (r_count != SAT)) begin
            r_count <= r_count + CW'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (LIMIT != 0) ? (r_count == LAST) : 1'b0;

endmodule

// File: rtl/apb4_master.sv
// -----------------------------------------------------------------------------
// apb4_master
// APB4 initiator: takes one read/write command at a time on a valid/ready
// command port, runs the SETUP and ACCESS phases on the APB bus and returns
// read data / error status on a valid/ready response port. An ACCESS phase
// that lasts TIMEOUT_CYCLES cycles without pready is aborted (0 disables).
// DATA_WIDTH must be 8, 16 or 32.
//   clk, rst                     : clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready    : command handshake
//   i_cmd_write/addr/wdata/strb/prot : command fields
//   o_rsp_valid / i_rsp_ready    : response handshake
//   o_rsp_rdata/err/timeout      : response fields
//   m                            : APB4 bus (master modport)
// All outputs come straight from flops and reset to 0.
// -----------------------------------------------------------------------------
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_strb,
    input  logic [APB4_PROT_W-1:0]    i_cmd_prot,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout,
    apb4_master_if.master             m
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef struct packed {
        logic                   write;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  wdata;
        logic [STRB_W-1:0]      strb;
        logic [APB4_PROT_W-1:0] prot;
    } apb4_cmd_t;

    apb4_state_e            r_state;
    apb4_cmd_t              r_cmd;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_err;
    logic                   r_rsp_timeout;

    apb4_cmd_t              w_cmd;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;
    logic                   w_expired;

    // Bus image of the incoming command: reads carry zero data and strobes.
    always_comb begin
        w_cmd.write = i_cmd_write;
        w_cmd.addr  = i_cmd_addr;
        w_cmd.prot  = i_cmd_prot;
        if (i_cmd_write) begin
            w_cmd.wdata = i_cmd_wdata;
            w_cmd.strb  = i_cmd_strb;
        end else begin
            w_cmd.wdata = {DATA_WIDTH{1'b0}};
            w_cmd.strb  = {STRB_W{1'b0}};
        end
    end

    assign w_cnt_clr = (r_state == SETUP);
    assign w_cnt_en  = (r_state == ACCESS) && !m.pready;

    apb4_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cmd         <= {$bits(apb4_cmd_t){1'b0}};
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd       <= w_cmd;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= SETUP;
                    end else begin
                        // Also raises ready on the first cycle after reset.
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins even on the cycle the timeout would fire.
                    if (m.pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_cmd.write ? {DATA_WIDTH{1'b0}} : m.prdata;
                        r_rsp_err     <= m.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RESP;
                    end else if (w_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_state <= ACCESS;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

    assign m.psel    = r_psel;
    assign m.penable = r_penable;
    assign m.pwrite  = r_cmd.write;
    assign m.paddr   = r_cmd.addr;
    assign m.pwdata  = r_cmd.wdata;
    assign m.pstrb   = r_cmd.strb;
    assign m.pprot   = r_cmd.prot;

endmodule

// File: tb/tb_apb4_master.sv
// -----------------------------------------------------------------------------
// tb_apb4_master
// Self-checking bench for apb4_master (TIMEOUT_CYCLES = 4). A table of
// directed transfers and a batch of random ones are run through one
// transfer task that plays the completer; expected responses come from the
// transfer rules (wait count versus timeout, read/write, slave error).
// A hand-written sequence covers reset in the middle of ACCESS.
// -----------------------------------------------------------------------------
module tb_apb4_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = 32'h0;
    logic [DW-1:0] cmd_wdata = 32'h0;
    logic [SW-1:0] cmd_strb = 4'h0;
    logic [2:0]    cmd_prot = 3'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    int total = 0;
    int bad   = 0;

    apb4_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .i_cmd_strb    (cmd_strb),
        .i_cmd_prot    (cmd_prot),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .m             (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;      // ACCESS cycles with pready=0 before pready=1
        logic [DW-1:0] rd_in;
        logic          slverr;
        int            rsp_delay;  // cycles with rsp_ready=0 before accepting
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input logic [2:0] p, input int wt,
                                input logic [DW-1:0] rd, input logic se, input int dl,
                                input logic [DW-1:0] erd, input logic ee, input logic eto);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p; v.waits = wt;
        v.rd_in = rd; v.slverr = se; v.rsp_delay = dl;
        v.exp_rdata = erd; v.exp_err = ee; v.exp_to = eto;
        return v;
    endfunction

    // Reference response: a transfer that sees pready within TO ACCESS cycles
    // completes normally, otherwise it times out.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        if (v.waits >= TO) begin
            r.exp_rdata = 32'h0; r.exp_err = 1'b1; r.exp_to = 1'b1;
        end else begin
            r.exp_rdata = v.write ? 32'h0 : v.rd_in;
            r.exp_err   = v.slverr;
            r.exp_to    = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [71:0] exp_bus(input vec_t v);
        return {v.write, v.addr, v.write ? v.wdata : 32'h0, v.write ? v.strb : 4'h0, v.prot};
    endfunction

    function automatic logic [71:0] bus_now();
        return {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot};
    endfunction

    function automatic logic [109:0] all_outs();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                bus.psel, bus.penable, bus_now()};
    endfunction

    task automatic junk_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    // One complete transfer; entered and left at a negedge with the DUT idle.
    task automatic xfer(input vec_t v);
        logic [71:0] eb;
        int nacc;
        eb   = exp_bus(v);
        nacc = (v.waits < TO) ? v.waits + 1 : TO;
        chk("idle_ready", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b0010);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
        @(negedge clk);
        cmd_valid = 1'b0;
        junk_cmd();
        chk("setup_ctl", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b1000);
        chk("setup_bus", bus_now(), eb);
        for (int k = 0; k < nacc; k++) begin
            @(negedge clk);
            chk("access_ctl", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b1100);
            chk("access_bus", bus_now(), eb);
            if (k == v.waits) begin
                bus.pready = 1'b1; bus.prdata = v.rd_in; bus.pslverr = v.slverr;
            end else begin
                // pslverr without pready must be ignored
                bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'b1;
            end
        end
        @(negedge clk);
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = $urandom;
        for (int d = 0; d <= v.rsp_delay; d++) begin
            chk("resp_ctl", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b0001);
            chk("resp_data", {rsp_rdata, rsp_err, rsp_timeout}, {v.exp_rdata, v.exp_err, v.exp_to});
            chk("resp_bus_hold", bus_now(), eb);
            // A competing command during RESP must not be taken.
            cmd_valid = 1'b1;
            junk_cmd();
            rsp_ready = (d == v.rsp_delay);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("after_accept", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b0010);
    endtask

    initial begin
        vec_t v;
        bus.pready = 1'b0; bus.prdata = 32'h0; bus.pslverr = 1'b0;

        // Directed cases with hand-derived expectations.
        vecs.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 32'hFFFF0000, 1'b0, 0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h20, 32'h00000055, 4'hF, 3'h2, 3, 32'h12345678, 1'b0, 1, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h30, 32'h00000BAD, 4'h3, 3'h1, 0, 32'h0, 1'b1, 0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 32'h34, 32'h0, 4'h0, 3'h0, 2, 32'hA5A5A5A5, 1'b0, 0, 32'hA5A5A5A5, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h38, 32'h0, 4'h0, 3'h4, 2, 32'h00000011, 1'b1, 0, 32'h00000011, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 32'h44, 32'h0, 4'hF, 3'h0, 9, 32'h99999999, 1'b0, 0, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 32'h48, 32'h12121212, 4'h0, 3'h7, 4, 32'h0, 1'b0, 2, 32'h0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 32'h4C, 32'h00000077, 4'h0, 3'h0, 0, 32'h0, 1'b0, 5, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h50, 32'h0, 4'h0, 3'h0, 3, 32'hBEEF0001, 1'b0, 5, 32'hBEEF0001, 1'b0, 1'b0));

        // Random transfers, expectations from the reference model.
        for (int i = 0; i < 25; i++) begin
            v = mk(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                   int'($urandom_range(0, 6)), $urandom, 1'($urandom),
                   int'($urandom_range(0, 3)), 32'h0, 1'b0, 1'b0);
            vecs.push_back(model(v));
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_outs", {18'h0, all_outs()}, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i]);
        end

        // Reset in the middle of ACCESS wait states.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
        cmd_wdata = 32'h0; cmd_strb = 4'h0; cmd_prot = 3'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        bus.pready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", {18'h0, all_outs()}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held_outs", {18'h0, all_outs()}, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {bus.psel, bus.penable, cmd_ready, rsp_valid}, 4'b0010);
        xfer(mk(1'b0, 32'h80, 32'h0, 4'hF, 3'h1, 1, 32'hCAFEF00D, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
